// File: rtl/sine_table_pkg.sv
// Shared constants and FSM state encoding for the sine-table loader.
package sine_table_pkg;
    localparam int unsigned TABLE_DEPTH = 256;
    localparam int unsigned TABLE_AW    = 8;
    localparam int unsigned TABLE_DW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_VERIFY,
        ST_DONE
    } state_t;
endpackage

// File: rtl/sine_table_loader_if.sv
// Word stream plus single RAM port (csb0/web0/wmask0/addr0/din0/dout0) of the sine table.
interface sine_table_loader_if
    import sine_table_pkg::*;
#(
    parameter int unsigned AW = TABLE_AW,
    parameter int unsigned DW = TABLE_DW
);
    logic              s_valid;
    logic [DW-1:0]     s_data;
    logic              s_ready;
    logic              csb0;
    logic              web0;
    logic [DW/8-1:0]   wmask0;
    logic [AW-1:0]     addr0;
    logic [DW-1:0]     din0;
    logic [DW-1:0]     dout0;

    // Loader side: consumes the stream, drives the RAM port
    modport master (
        input  s_valid, s_data, dout0,
        output s_ready, csb0, web0, wmask0, addr0, din0
    );

    // Producer / RAM side
    modport slave (
        output s_valid, s_data, dout0,
        input  s_ready, csb0, web0, wmask0, addr0, din0
    );
endinterface

// File: rtl/sine_ram_port_drv.sv
// Registers the RAM port pins from a one-cycle issue request (write or read).
module sine_ram_port_drv
    import sine_table_pkg::*;
#(
    parameter int unsigned AW = TABLE_AW,
    parameter int unsigned DW = TABLE_DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              issue,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     data,
    output logic              csb0,
    output logic              web0,
    output logic [DW/8-1:0]   wmask0,
    output logic [AW-1:0]     addr0,
    output logic [DW-1:0]     din0
);
    localparam int unsigned MW = DW / 8;

    // Port pins: idle values on reset/clear, otherwise follow the request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
        end else if (clear) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
        end else begin
            csb0   <= !issue;
            web0   <= !(issue && we);
            wmask0 <= (issue && we) ? {MW{1'b1}} : '0;
            if (issue) begin
                addr0 <= addr;
            end
            if (issue && we) begin
                din0 <= data;
            end
        end
    end
endmodule

// File: rtl/sine_table_loader.sv
// Streams DEPTH words into the sine-table RAM at addresses 0..DEPTH-1.
// Define SINE_LOADER_VERIFY_EN to add a readback pass that compares a
// checksum of the read data against a checksum of the written data.
module sine_table_loader
    import sine_table_pkg::*;
#(
    parameter int unsigned DEPTH = TABLE_DEPTH,
    parameter int unsigned AW    = TABLE_AW,
    parameter int unsigned DW    = TABLE_DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    sine_table_loader_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int unsigned CW = AW + 1;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            ready_n, busy_n, done_n, error_n;
    logic            req_issue, req_we, req_clear;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_data;
    logic            beat;

`ifdef SINE_LOADER_VERIFY_EN
    logic [DW-1:0]   sum_w, sum_w_n, sum_r, sum_r_n;
`else
    logic            dout0_unused;
    assign dout0_unused = ^bus.dout0;
`endif

    assign beat = bus.s_valid && bus.s_ready;

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bus.s_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
`ifdef SINE_LOADER_VERIFY_EN
            sum_w       <= '0;
            sum_r       <= '0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bus.s_ready <= ready_n;
            busy        <= busy_n;
            done        <= done_n;
            error       <= error_n;
`ifdef SINE_LOADER_VERIFY_EN
            sum_w       <= sum_w_n;
            sum_r       <= sum_r_n;
`endif
        end
    end

    // Next state, RAM requests and next output values
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ready_n   = 1'b0;
        error_n   = error;
        req_issue = 1'b0;
        req_we    = 1'b0;
        req_addr  = cnt[AW-1:0];
        req_data  = bus.s_data;
`ifdef SINE_LOADER_VERIFY_EN
        sum_w_n   = sum_w;
        sum_r_n   = sum_r;
`endif
        if (abort) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_n = ST_WRITE;
                        cnt_n   = '0;
                        ready_n = 1'b1;
                        error_n = 1'b0;
`ifdef SINE_LOADER_VERIFY_EN
                        sum_w_n = '0;
                        sum_r_n = '0;
`endif
                    end
                end
                ST_WRITE: begin
                    if (cnt == CW'(DEPTH)) begin
                        // Last write is on the port this cycle; move on
                        cnt_n = '0;
`ifdef SINE_LOADER_VERIFY_EN
                        state_n   = ST_VERIFY;
                        req_issue = 1'b1;
                        req_addr  = '0;
`else
                        state_n   = ST_DONE;
`endif
                    end else begin
                        ready_n = 1'b1;
                        if (beat) begin
                            req_issue = 1'b1;
                            req_we    = 1'b1;
                            cnt_n     = cnt + CW'(1);
                            ready_n   = (cnt != CW'(DEPTH - 1));
`ifdef SINE_LOADER_VERIFY_EN
                            sum_w_n   = sum_w + bus.s_data;
`endif
                        end
                    end
                end
                ST_VERIFY: begin
`ifdef SINE_LOADER_VERIFY_EN
                    // cnt = cycles spent here; dout0 holds the read issued one cycle earlier
                    cnt_n = cnt + CW'(1);
                    if (cnt < CW'(DEPTH - 1)) begin
                        req_issue = 1'b1;
                        req_addr  = AW'(cnt + CW'(1));
                    end
                    if (cnt != '0) begin
                        sum_r_n = sum_r + bus.dout0;
                    end
                    if (cnt == CW'(DEPTH)) begin
                        state_n = ST_DONE;
                        error_n = ((sum_r + bus.dout0) != sum_w);
                    end
`else
                    state_n = ST_IDLE;
`endif
                end
                ST_DONE: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
`ifndef SINE_LOADER_VERIFY_EN
        error_n = 1'b0;
`endif
        busy_n    = (state_n != ST_IDLE);
        done_n    = (state_n == ST_DONE);
        req_clear = (state_n == ST_IDLE);
    end

    sine_ram_port_drv #(
        .AW (AW),
        .DW (DW)
    ) u_port (
        .clk    (clk),
        .reset  (reset),
        .clear  (req_clear),
        .issue  (req_issue),
        .we     (req_we),
        .addr   (req_addr),
        .data   (req_data),
        .csb0   (bus.csb0),
        .web0   (bus.web0),
        .wmask0 (bus.wmask0),
        .addr0  (bus.addr0),
        .din0   (bus.din0)
    );
endmodule

// File: tb/tb_sine_table_loader.sv
// Scoreboard bench for sine_table_loader with a behavioural RAM and table model.
module tb_sine_table_loader;
    import sine_table_pkg::*;

    localparam int unsigned DEPTH = TABLE_DEPTH;
`ifdef SINE_LOADER_VERIFY_EN
    localparam int LOAD_CYCLES = 258 + 257;
    localparam int READS       = 256;
`else
    localparam int LOAD_CYCLES = 258;
    localparam int READS       = 0;
`endif

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, error;

    sine_table_loader_if bus ();

    sine_table_loader dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          rd_seq = 0;
    bit          prefill = 1'b0;
    bit          fault17 = 1'b0;
    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    wr_t         exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sine_word(input int i);
        real r;
        r = $sin(2.0 * 3.14159265358979323846 * real'(i) / 256.0) * 2147483647.0;
        return 32'(int'(r));
    endfunction

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem[i] !== ref_mem[i]) d++;
        end
        return d;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: byte-masked writes, 1-cycle read latency, optional bit-0 fault on addr 17
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'hDEAD_0000 | 32'(i);
        end else if (!bus.csb0) begin
            if (!bus.web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.wmask0[b]) mem[bus.addr0][8*b +: 8] <= bus.din0[8*b +: 8];
                end
            end else begin
                bus.dout0 <= mem[bus.addr0] ^ {31'b0, (fault17 && bus.addr0 == 8'd17)};
            end
        end
    end

    // Monitor: pops expected writes, checks read sequencing, counts done pulses
    always @(negedge clk) begin
        if (reset) begin
            if (done) done_cnt++;
            if (!bus.csb0 && !bus.web0) begin
                if (exp_q.size() == 0) begin
                    check("wr_expected", 64'(exp_q.size() != 0), 64'(1));
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.addr0), 64'(e.addr));
                    check("wr_data", 64'(bus.din0), 64'(e.data));
                    check("wr_mask", 64'(bus.wmask0), 64'(4'hF));
                end
            end
            if (!bus.csb0 && bus.web0) begin
                check("rd_addr", 64'(bus.addr0), 64'(rd_seq));
                check("rd_mask", 64'(bus.wmask0), 64'(0));
                rd_seq++;
            end
        end
    end

    // One load; mode 0 = sine/always valid, 1 = A5 ramp/toggled valid, 2 = random
    task automatic run_load(input int mode, input int abort_at, input bit abort_start,
                            input int start_mid, output int elapsed, output logic err_done);
        int n = 0;
        int k = 0;
        int t0;
        int d0;
        bit fin = 1'b0;
        elapsed  = -1;
        err_done = 1'b0;
        rd_seq   = 0;
        d0       = done_cnt;
        start    = 1'b1;
        t0       = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        check("ready_after_start", 64'(bus.s_ready), 64'(1));
        check("error_clear_on_start", 64'(error), 64'(0));
        while (!fin && k < 3000) begin
            if (done) begin
                elapsed  = cyc - t0;
                err_done = error;
                fin      = 1'b1;
            end else if (abort_at >= 0 && n == abort_at) begin
                abort       = 1'b1;
                start       = abort_start;
                bus.s_valid = 1'b1;
                bus.s_data  = 32'hBAD0_BAD0;
                @(negedge clk);
                abort       = 1'b0;
                start       = 1'b0;
                bus.s_valid = 1'b0;
                check("busy_after_abort", 64'(busy), 64'(0));
                check("ready_after_abort", 64'(bus.s_ready), 64'(0));
                fin = 1'b1;
            end else begin
                case (mode)
                    0:       begin bus.s_valid = 1'b1;        bus.s_data = sine_word(n); end
                    1:       begin bus.s_valid = (k % 2 == 0); bus.s_data = 32'hA500_0000 + 32'(n); end
                    default: begin bus.s_valid = ($urandom_range(0, 3) != 0); bus.s_data = $urandom; end
                endcase
                start = (k == start_mid);
                if (bus.s_valid && bus.s_ready) begin
                    exp_q.push_back('{addr: 8'(n), data: bus.s_data});
                    ref_mem[n] = bus.s_data;
                    n++;
                end
                @(negedge clk);
                k++;
            end
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
        check("load_finished", 64'(fin), 64'(1));
        repeat (4) @(negedge clk);
        check("done_pulses", 64'(done_cnt - d0), (abort_at >= 0) ? 64'(0) : 64'(1));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        check("mem_image_diffs", 64'(mem_diffs()), 64'(0));
    endtask

    task automatic full_load(input int mode, input int start_mid, input logic exp_err);
        int          el;
        logic        ed;
        run_load(mode, -1, 1'b0, start_mid, el, ed);
        if (mode == 0) check("done_latency", 64'(el), 64'(LOAD_CYCLES));
        check("error_at_done", 64'(ed), 64'(exp_err));
        check("read_cycles", 64'(rd_seq), 64'(READS));
    endtask

    initial begin
        int   el;
        logic ed;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'hDEAD_0000 | 32'(i);

        // Reset: low for 3 clocks, RAM pre-filled and untouched
        #2 reset = 1'b0;
        prefill  = 1'b1;
        @(negedge clk);
        prefill = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_csb0", 64'(bus.csb0), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        check("idle_csb0", 64'(bus.csb0), 64'(1));
        check("idle_web0", 64'(bus.web0), 64'(1));
        check("idle_ready", 64'(bus.s_ready), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_done", 64'(done), 64'(0));
        check("idle_error", 64'(error), 64'(0));
        check("idle_wmask", 64'(bus.wmask0), 64'(0));
        check("idle_addr", 64'(bus.addr0), 64'(0));
        check("idle_din", 64'(bus.din0), 64'(0));
        check("ram_untouched", 64'(mem_diffs()), 64'(0));

        // start+abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", 64'(busy), 64'(0));

        // Full sine load
        full_load(0, -1, 1'b0);
        check("mem64_peak", 64'(mem[64]), 64'(32'h7FFF_FFFF));

        // Toggled valid, A5 ramp
        full_load(1, -1, 1'b0);

        // Abort after 100 beats, then reload from address 0
        run_load(0, 100, 1'b0, -1, el, ed);
        full_load(1, -1, 1'b0);

        // start while busy is ignored
        full_load(0, 50, 1'b0);

        // start+abort together during WRITE, random traffic
        run_load(2, 60, 1'b1, -1, el, ed);
        full_load(2, -1, 1'b0);

        // Async reset mid-load: outputs drop at once
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = $urandom;
            exp_q.push_back('{addr: 8'(n), data: bus.s_data});
            ref_mem[n] = bus.s_data;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_rst_csb0", 64'(bus.csb0), 64'(1));
        check("async_rst_web0", 64'(bus.web0), 64'(1));
        check("async_rst_ready", 64'(bus.s_ready), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("async_rst_queue", 64'(exp_q.size()), 64'(0));
        check("async_rst_mem", 64'(mem_diffs()), 64'(0));

`ifdef SINE_LOADER_VERIFY_EN
        // Corrupted readback on address 17 must flag error; next start clears it
        fault17 = 1'b1;
        full_load(2, -1, 1'b1);
        fault17 = 1'b0;
        check("error_sticky", 64'(error), 64'(1));
        full_load(0, -1, 1'b0);
`else
        full_load(2, -1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
